ss_step_sequencer: RTL
======================

Name: ss_step_sequencer

Overview:
- Sequences one discrete state-space update per simulation tick on the shared multiply-accumulate datapath: x[k+1] = Ah*x[k] + Bh*u, then y = C*x[k+1].
- Selects the Ah_on/Bh_on or Ah_off/Bh_off bank from the switch state latched at step start.
- Sits between the AXI-stream parameter loader (size, ready) and the MAC array. Emits matrix indices, accumulator control and state-swap strobes.
- Never starts a step while parameters are being loaded.

Parameters:
- N_MAX, 6, maximum system order; size is clamped to this value.
- IDX_W, 3, index width; must satisfy 2^IDX_W > N_MAX.
- OUT_W, 8, width of the skipped-tick counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-low (rst==0 resets on the rising edge of clk).
- en  in  1  global enable; en==0 freezes all state, and issue outputs read 0.
- step_tick  in  1  one-cycle request to compute a step.
- cfg_ready  in  1  parameter loader idle; parameters are stable while high.
- size  in  8  active system order.
- sw_state  in  1  switch state; 1 selects the on bank, 0 the off bank.
- mac_ready  in  1  datapath accepts an issue this cycle.
- mac_res_valid  in  1  one row result retired by the datapath.
- mac_valid  out  1  issue valid.
- mac_op  out  2  0 = A term, 1 = B term, 2 = C term.
- mac_bank  out  1  latched sw_state.
- mac_row  out  IDX_W  row index.
- mac_col  out  IDX_W  column index; 0 for B terms.
- mac_first  out  1  first term of a row; clear the accumulator.
- mac_last  out  1  last term of a row; retire the row.
- x_swap  out  1  one-cycle pulse: commit x[k+1] as x[k].
- busy  out  1  state is not IDLE.
- step_done  out  1  one-cycle pulse when y is complete.
- skip_cnt  out  OUT_W  ticks dropped; saturates at all-ones.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, all counters 0, all outputs 0. This takes priority over en and applies mid-step; in-flight datapath results are abandoned.
- n = min(size, N_MAX), latched together with sw_state when leaving IDLE.
- States: IDLE, UPD, DRAIN_U, SWAP, OUT, DRAIN_O, DONE.
- IDLE: on en && step_tick && cfg_ready && n!=0, go to UPD; row=0, col=0.
- IDLE, tick with cfg_ready==0 or n==0: stay in IDLE and increment skip_cnt.
- Tick in any non-IDLE state: tick is dropped and skip_cnt increments. No queuing.
- UPD: each issue carries mac_op=0 for col=0..n-1, then one term with mac_op=1, col=0.
  - mac_first=1 on col 0 of the A sequence; mac_last=1 on the B term.
  - After each row's B term, row increments. After the row n-1 B term, go to DRAIN_U.
- Issue handshake: a term is consumed only when mac_valid && mac_ready. Otherwise all issue outputs hold stable. mac_valid stays asserted in UPD and OUT.
- Outstanding counter (width IDX_W+1):
  - +1 on an accepted issue with mac_last.
  - -1 on mac_res_valid.
  - Simultaneous +1 and -1 leaves it unchanged.
  - mac_res_valid while the counter is 0 is ignored; no underflow.
- DRAIN_U: wait for outstanding==0, then go to SWAP.
- SWAP: x_swap=1 for exactly one cycle, then OUT with row=0, col=0.
- OUT: mac_op=2, col=0..n-1 per row. mac_first on col 0, mac_last on col n-1. After row n-1, go to DRAIN_O.
- DRAIN_O: wait for outstanding==0, then go to DONE.
- DONE: step_done=1 for one cycle, then IDLE.
- cfg_ready falling mid-step does not abort; the step completes using the latched n and bank.
- Issue count per step: n*(n+1) UPD terms plus n*n OUT terms. With mac_ready held at 1, UPD lasts exactly n*(n+1) cycles and OUT exactly n*n cycles.
- en==0: no transitions, counters hold, mac_valid=0, x_swap=0, step_done=0. Resumes exactly where it stopped.

Test Plan:
- Reset mid-step: rst=0 during UPD -> next cycle busy=0, mac_valid=0, skip_cnt=0; a following tick starts cleanly at row 0, col 0.
- n=2, sw_state=1, mac_ready=1, results returned 3 cycles after each mac_last:
  - UPD issue sequence (op,row,col) = (0,0,0)(0,0,1)(1,0,0)(0,1,0)(0,1,1)(1,1,0), all with bank=1.
  - x_swap pulses once; OUT issues 4 C terms; step_done pulses once; busy falls the cycle after.
- Backpressure: toggle mac_ready every cycle with n=3 -> 12 UPD + 9 OUT issues accepted, none duplicated or skipped; outputs stable whenever mac_ready=0.
- Tick rules:
  - Tick while busy -> skip_cnt=1, step continues unaffected.
  - Tick with cfg_ready=0 -> skip_cnt=2, busy stays 0.
  - size=0 -> skip_cnt increments, no issues.
- size=9 -> clamped to n=6: 42 UPD issues and 36 OUT issues; max row and col = 5.
- en=0 for 5 cycles in DRAIN_U while mac_res_valid pulses -> state and outstanding count frozen; after en=1, x_swap fires only once outstanding reaches 0.

Source files
------------

// File: rtl/ss_step_sequencer.sv
// ss_step_sequencer
// Runs one discrete state-space update per accepted step_tick on the shared
// MAC datapath: x[k+1] = Ah*x[k] + Bh*u (UPD), commit x (SWAP), then
// y = C*x[k+1] (OUT). The system order and the switch bank are captured when
// the step starts, so the loader may change them while a step is running.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   en                global enable; 0 freezes everything and blanks strobes
//   step_tick         one-cycle step request (dropped and counted if not taken)
//   cfg_ready         parameter loader idle; a step only starts while high
//   size, sw_state    requested order and switch state
//   mac_ready         datapath accepts the presented term this cycle
//   mac_res_valid     datapath retired one row
//   mac_*             issued term: op (0 A, 1 B, 2 C), bank, row, col, first, last
//   x_swap            one-cycle pulse: commit x[k+1] as x[k]
//   busy              sequencer not idle
//   step_done         one-cycle pulse when y is complete
//   skip_cnt          saturating count of dropped ticks
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for step_tick
// UPD     | issuing A terms then one B term per row of x[k+1]
// DRAIN_U | waiting for all UPD rows to retire
// SWAP    | x_swap pulse
// OUT     | issuing C terms per row of y
// DRAIN_O | waiting for all OUT rows to retire
// DONE    | step_done pulse
module ss_step_sequencer #(
    parameter int N_MAX = 6,
    parameter int IDX_W = 3,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step_tick,
    input  logic             cfg_ready,
    input  logic [7:0]       size,
    input  logic             sw_state,
    input  logic             mac_ready,
    input  logic             mac_res_valid,
    output logic             mac_valid,
    output logic [1:0]       mac_op,
    output logic             mac_bank,
    output logic [IDX_W-1:0] mac_row,
    output logic [IDX_W-1:0] mac_col,
    output logic             mac_first,
    output logic             mac_last,
    output logic             x_swap,
    output logic             busy,
    output logic             step_done,
    output logic [OUT_W-1:0] skip_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UPD     = 3'd1,
        DRAIN_U = 3'd2,
        SWAP    = 3'd3,
        OUT     = 3'd4,
        DRAIN_O = 3'd5,
        DONE    = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [IDX_W-1:0] col;
        logic             first;
        logic             last;
    } term_t;

    localparam logic [7:0]       N_MAX_SZ  = 8'(N_MAX);
    localparam logic [IDX_W-1:0] N_MAX_IDX = IDX_W'(N_MAX);

    state_t           state_q;
    logic [IDX_W-1:0] n_q;
    logic             bank_q;
    logic [IDX_W-1:0] row_q;
    // UPD: term 0..n-1 are A columns, term n is the B term. OUT: term = column.
    logic [IDX_W-1:0] term_q;
    term_t            iss_q;
    logic             valid_q;
    logic             swap_q;
    logic             done_q;
    logic [IDX_W:0]   outst_q;
    logic [OUT_W-1:0] skip_q;

    logic [IDX_W-1:0] n_in;
    logic             accept;
    logic             retire_inc;
    logic             retire_dec;
    logic             start_ok;
    logic             issue_on;

    function automatic term_t upd_term(input logic [IDX_W-1:0] t, input logic [IDX_W-1:0] nn);
        term_t f;
        f.op    = (t == nn) ? 2'd1 : 2'd0;
        f.col   = (t == nn) ? '0 : t;
        f.first = (t == '0);
        f.last  = (t == nn);
        return f;
    endfunction

    function automatic term_t out_term(input logic [IDX_W-1:0] t, input logic [IDX_W-1:0] nn);
        term_t f;
        f.op    = 2'd2;
        f.col   = t;
        f.first = (t == '0);
        f.last  = (t == nn - 1'b1);
        return f;
    endfunction

    always_comb begin
        if (size > N_MAX_SZ) begin
            n_in = N_MAX_IDX;
        end else begin
            n_in = size[IDX_W-1:0];
        end
    end

    assign accept     = en && valid_q && mac_ready;
    assign retire_inc = accept && iss_q.last;
    // A retire with nothing outstanding is stray and must not wrap the count.
    assign retire_dec = mac_res_valid && (outst_q != '0);
    assign start_ok   = (state_q == IDLE) && cfg_ready && (n_in != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            bank_q  <= 1'b0;
            row_q   <= '0;
            term_q  <= '0;
            iss_q   <= '0;
            valid_q <= 1'b0;
            swap_q  <= 1'b0;
            done_q  <= 1'b0;
            outst_q <= '0;
            skip_q  <= '0;
        end else if (en) begin
            if (retire_inc && !retire_dec) begin
                outst_q <= outst_q + 1'b1;
            end else if (!retire_inc && retire_dec) begin
                outst_q <= outst_q - 1'b1;
            end

            if (step_tick && !start_ok && (skip_q != '1)) begin
                skip_q <= skip_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (step_tick && start_ok) begin
                        state_q <= UPD;
                        n_q     <= n_in;
                        bank_q  <= sw_state;
                        row_q   <= '0;
                        term_q  <= '0;
                        iss_q   <= upd_term('0, n_in);
                        valid_q <= 1'b1;
                    end
                end
                UPD: begin
                    if (accept) begin
                        if (term_q == n_q) begin
                            term_q <= '0;
                            iss_q  <= upd_term('0, n_q);
                            if (row_q == n_q - 1'b1) begin
                                state_q <= DRAIN_U;
                                valid_q <= 1'b0;
                                row_q   <= '0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            term_q <= term_q + 1'b1;
                            iss_q  <= upd_term(term_q + 1'b1, n_q);
                        end
                    end
                end
                DRAIN_U: begin
                    if (outst_q == '0) begin
                        state_q <= SWAP;
                        swap_q  <= 1'b1;
                    end
                end
                SWAP: begin
                    swap_q  <= 1'b0;
                    state_q <= OUT;
                    row_q   <= '0;
                    term_q  <= '0;
                    iss_q   <= out_term('0, n_q);
                    valid_q <= 1'b1;
                end
                OUT: begin
                    if (accept) begin
                        if (term_q == n_q - 1'b1) begin
                            term_q <= '0;
                            iss_q  <= out_term('0, n_q);
                            if (row_q == n_q - 1'b1) begin
                                state_q <= DRAIN_O;
                                valid_q <= 1'b0;
                                row_q   <= '0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            term_q <= term_q + 1'b1;
                            iss_q  <= out_term(term_q + 1'b1, n_q);
                        end
                    end
                end
                DRAIN_O: begin
                    if (outst_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    swap_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are blanked while disabled so a frozen SWAP/DONE cannot repeat.
    assign issue_on  = en && valid_q;
    assign mac_valid = issue_on;
    assign mac_op    = issue_on ? iss_q.op    : 2'd0;
    assign mac_bank  = issue_on ? bank_q      : 1'b0;
    assign mac_row   = issue_on ? row_q       : '0;
    assign mac_col   = issue_on ? iss_q.col   : '0;
    assign mac_first = issue_on ? iss_q.first : 1'b0;
    assign mac_last  = issue_on ? iss_q.last  : 1'b0;
    assign x_swap    = en && swap_q;
    assign step_done = en && done_q;
    assign busy      = (state_q != IDLE);
    assign skip_cnt  = skip_q;

endmodule
